// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide controller.
//   - mdu_state_e : controller state encoding
//   - DIV_CYCLES  : number of restoring-division iterations
//   - CNT_W       : width of the iteration counter
//   - ALU_*       : MDU opcodes, mirroring the encodings in aludefines.vh
//   - helper functions classifying an ALU opcode
package mdu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_e;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 5;

    // Must stay bit-identical to the ALU decoder's aludefines.vh values.
    localparam logic [4:0] ALU_MULT  = 5'b11000;
    localparam logic [4:0] ALU_MULTU = 5'b11001;
    localparam logic [4:0] ALU_DIV   = 5'b11010;
    localparam logic [4:0] ALU_DIVU  = 5'b11011;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// div_iter: unsigned restoring divider datapath, one quotient bit per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : load dividend/divisor and clear the partial remainder
//   step_i        : perform one shift/subtract iteration
//   dividend_i    : unsigned dividend (sampled on load_i)
//   divisor_i     : unsigned divisor  (sampled on load_i)
//   quot_o, rem_o : quotient and remainder after the final iteration
module div_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    // {remainder, quotient}: dividend bits shift out of the low half into
    // the high half while quotient bits shift in from the bottom.
    logic [63:0] rq_q, rq_d;
    logic [31:0] dvs_q, dvs_d;

    // The shifted remainder can reach 33 bits when the divisor exceeds
    // 2^31, so the trial subtraction is done one bit wider plus a borrow.
    logic [32:0] trial;
    logic [33:0] diff;

    always_comb begin
        trial = rq_q[63:31];
        diff  = {1'b0, trial} - {2'b00, dvs_q};
        rq_d  = rq_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rq_d  = {32'h0, dividend_i};
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!diff[33]) begin
                rq_d = {diff[31:0], rq_q[30:0], 1'b1};
            end else begin
                rq_d = {rq_q[62:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_q  <= '0;
            dvs_q <= '0;
        end else begin
            rq_q  <= rq_d;
            dvs_q <= dvs_d;
        end
    end

    assign quot_o = rq_q[31:0];
    assign rem_o  = rq_q[63:32];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller for the EX stage.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : EX-stage instruction valid
//   alucontrol_i : ALU opcode; MULT/MULTU/DIV/DIVU are accepted
//   a_i, b_i     : rs / rt operands (only sampled in the accept cycle)
//   flush_i      : cancels any operation in flight, suppresses the write
//   stall_o      : combinational pipeline stall request
//   hilo_we_o    : one-cycle HI/LO write strobe
//   hi_o, lo_o   : result; change only on entry to DONE, otherwise held
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [4:0]  alucontrol_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        accept;
    logic        op_signed;
    logic [31:0] a_mag, b_mag;
    logic        div_load, div_step;
    logic [31:0] div_quot, div_rem;
    logic [63:0] a_ext, b_ext, prod;

    assign op_signed = is_signed_op(alucontrol_i);
    assign accept    = (state_q == S_IDLE) && start_i && !flush_i &&
                       is_mdu_op(alucontrol_i);

    // The divider only ever sees magnitudes; signs are restored in FIX.
    assign a_mag = (op_signed && a_i[31]) ? -a_i : a_i;
    assign b_mag = (op_signed && b_i[31]) ? -b_i : b_i;

    assign div_load = accept && is_div_op(alucontrol_i);
    assign div_step = (state_q == S_DIV) && !flush_i;

    div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Low 64 bits of the extended product are correct for both signedness.
    assign a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    assign b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    assign prod  = a_ext * b_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_o   = 1'b0;
        hilo_we_o = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        stall_o = 1'b1;
                        a_d     = a_i;
                        b_d     = b_i;
                        sgn_d   = op_signed;
                        q_neg_d = op_signed && (a_i[31] ^ b_i[31]);
                        r_neg_d = op_signed && a_i[31];
                        cnt_d   = '0;
                        state_d = is_div_op(alucontrol_i) ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    stall_o = 1'b1;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = S_DONE;
                end
                S_DIV: begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    stall_o = 1'b1;
                    if (b_q == 32'h0) begin
                        // Report the original (signed) dividend, not its magnitude.
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = r_neg_q ? -div_rem  : div_rem;
                        lo_d = q_neg_q ? -div_quot : div_quot;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    // start_i here still belongs to the completing instruction.
                    hilo_we_o = 1'b1;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [4:0]  alucontrol_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] ALU_ADD = 5'b00000;

    mdu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .alucontrol_i (alucontrol_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the rising edge, then wait to the falling
    // edge where outputs are sampled.
    task automatic cyc(input logic s, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
        @(posedge clk);
        #1;
        start_i      = s;
        alucontrol_i = op;
        a_i          = a;
        b_i          = b;
        flush_i      = fl;
        @(negedge clk);
    endtask

    // Full operation with start held through DONE; checks stall/we every
    // cycle, the result in DONE, and that the result holds afterwards.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int c = 0; c <= lat; c++) begin
            cyc(1'b1, op, a, b, 1'b0);
            chk({tag, "_stall"}, {31'h0, stall_o}, (c < lat) ? 32'h1 : 32'h0);
            chk({tag, "_we"}, {31'h0, hilo_we_o}, (c == lat) ? 32'h1 : 32'h0);
            if (c == lat) begin
                chk({tag, "_hi"}, hi_o, exp_hi);
                chk({tag, "_lo"}, lo_o, exp_lo);
            end
        end
        cyc(1'b0, ALU_ADD, 32'h0, 32'h0, 1'b0);
        chk({tag, "_idle_stall"}, {31'h0, stall_o}, 32'h0);
        chk({tag, "_idle_we"}, {31'h0, hilo_we_o}, 32'h0);
        chk({tag, "_hold_hi"}, hi_o, exp_hi);
        chk({tag, "_hold_lo"}, lo_o, exp_lo);
        $display("op %s a=%h b=%h hi=%h lo=%h", tag, a, b, hi_o, lo_o);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        alucontrol_i = ALU_ADD;
        a_i          = '0;
        b_i          = '0;
        flush_i      = 1'b0;

        #12;
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_we", {31'h0, hilo_we_o}, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        $display("reset values checked");
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_m3x5", ALU_MULT, 32'hFFFF_FFFD, 32'h5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", ALU_DIV, 32'h7, 32'hFFFF_FFFE, 34, 32'h1, 32'hFFFF_FFFD);
        run_op("divu_100d7", ALU_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_op("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 34, 32'h7FFF_FFFE, 32'h1);
        run_op("divu_by0", ALU_DIVU, 32'h1234, 32'h0, 34, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_by0_neg", ALU_DIV, 32'hFFFF_FFF9, 32'h0, 34, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);

        // Flush mid-divide: no stall in the flush cycle, no write ever.
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, ALU_DIV, 32'd1000, 32'd3, 1'b0);
        end
        cyc(1'b1, ALU_DIV, 32'd1000, 32'd3, 1'b1);
        chk("flush_stall", {31'h0, stall_o}, 32'h0);
        chk("flush_we", {31'h0, hilo_we_o}, 32'h0);
        chk("flush_hi_hold", hi_o, 32'h0);
        chk("flush_lo_hold", lo_o, 32'h8000_0000);
        $display("flush at cycle 10 of DIV");
        run_op("mult_after_flush", ALU_MULT, 32'h0001_0000, 32'hFFFF_0000, 2, 32'hFFFF_FFFF, 32'h0);

        // Non-MDU op with start high never stalls or writes.
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, ALU_ADD, 32'h5, 32'h6, 1'b0);
            chk("nonmdu_stall", {31'h0, stall_o}, 32'h0);
            chk("nonmdu_we", {31'h0, hilo_we_o}, 32'h0);
        end
        $display("non-MDU op ignored");

        // Asynchronous reset in the middle of a divide.
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, ALU_DIVU, 32'd50, 32'd5, 1'b0);
        end
        start_i      = 1'b0;
        alucontrol_i = ALU_ADD;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_stall", {31'h0, stall_o}, 32'h0);
        chk("arst_we", {31'h0, hilo_we_o}, 32'h0);
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, ALU_ADD, 32'h0, 32'h0, 1'b0);
            chk("post_rst_we", {31'h0, hilo_we_o}, 32'h0);
        end
        chk("post_rst_lo", lo_o, 32'h0);
        $display("async reset mid-DIV checked");

        run_op("divu_after_rst", ALU_DIVU, 32'd50, 32'd5, 34, 32'd0, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
